cond_pipe: RTL and testbench
============================

# cond_pipe

Execute-to-writeback conditional-control pipeline for the pipelined ARM core. Holds the architectural NZCV flags register and drives it to the condition checker. It takes the checker's pass/fail result (CondExE) back and uses it to gate the execute-stage control signals. The gated controls are carried through the Memory and Writeback pipeline registers, with stall and flush support.

## Interface
Parameters:
- RA_W, default 4: width of the destination-register tag carried down the pipe.

Ports:
- clk, input, 1: core clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- Stall, input, 1: holds the M/W registers and the flags register.
- FlushE, input, 1: squashes the instruction currently in Execute.
- ValidE, input, 1: the Execute slot holds a real instruction.
- CondExE, input, 1: condition-check result for the Execute instruction.
- ALUFlagsE, input, 4: {N,Z,C,V} produced by the ALU in Execute.
- FlagWriteE, input, 2: [1] writes N,Z; [0] writes C,V.
- RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE, input, 1 each: ungated Execute controls.
- WA3E, input, RA_W: destination register tag.
- Flags, output, 4: registered {N,Z,C,V} to the condition checker.
- BranchTakenE, output, 1: combinational; BranchE & CondExE & ValidE & ~FlushE.
- RegWriteM, MemWriteM, MemtoRegM, PCSrcM, output, 1 each: Memory-stage gated controls.
- WA3M, output, RA_W: Memory-stage tag.
- RegWriteW, MemtoRegW, PCSrcW, output, 1 each: Writeback-stage gated controls.
- WA3W, output, RA_W: Writeback-stage tag.
- SquashCount, output, 16: count of condition-failed instructions (see Configuration).

## Operation
- Define the execute qualifier go = ValidE & CondExE & ~FlushE.
- Gated controls are the E controls ANDed with go. MemtoReg and WA3 pass ungated but are carried alongside.
- Flags update, only when Stall=0 and go=1:
  - FlagWriteE[1] loads Flags[3:2] from ALUFlagsE[3:2].
  - FlagWriteE[0] loads Flags[1:0] from ALUFlagsE[1:0].
  - Both bits set: all four flags load in the same cycle.
  - Both bits clear, or go=0: Flags hold.
- A condition-failed instruction never modifies Flags, even with FlagWriteE set.
- M register, when Stall=0: loads the gated E controls and WA3E. FlushE=1 or ValidE=0 loads a bubble: all M controls 0, WA3M 0.
- W register, when Stall=0: loads the M-stage values.
- Stall=1: the M register, W register and Flags all hold. FlushE is ignored that cycle, because the E instruction is re-presented by upstream.
- BranchTakenE is purely combinational and is not affected by Stall.
- reset=0, at any time including mid-pipe: Flags=0000, all M/W controls 0, WA3M=WA3W=0, SquashCount=0.

## Timing
- Flags written by an instruction in E at edge t are visible on Flags (and thus to the next E instruction's CondExE) after edge t. No bypass is needed.
- Latency: an E control appears on the M output 1 cycle later and on the W output 2 cycles later, with Stall low.
- Back-to-back flag-setting instructions each update in their own cycle.
- A condition-failed flag-setter followed by a dependent instruction: the dependent instruction sees the old flags.

## Configuration
- COND_PIPE_PERF_EN defined: SquashCount increments by 1 on each edge where Stall=0, ValidE=1, FlushE=0 and CondExE=0. It saturates at 16'hFFFF.
- COND_PIPE_PERF_EN undefined: SquashCount is tied to 0 and no counter logic is built.

## Test plan
- Reset release, then ADDS-like E (FlagWriteE=11, ALUFlagsE=0110, CondExE=1) -> Flags=0110 after 1 edge.
- FlagWriteE=01 with ALUFlagsE=1001 from Flags=0110 -> Flags=0101 (N,Z held; C,V written).
- CondExE=0 with RegWriteE=1, MemWriteE=1, FlagWriteE=11 -> RegWriteM=0, MemWriteM=0, Flags unchanged, SquashCount +1 (macro on).
- RegWriteE=1, WA3E=5, CondExE=1 -> RegWriteM=1/WA3M=5 at +1 cycle, RegWriteW=1/WA3W=5 at +2 cycles.
- Hold Stall=1 for 3 cycles mid-pipe with FlushE=1 -> M/W outputs and Flags frozen, flush ignored. After Stall drops, normal advance resumes.
- Assert reset=0 asynchronously between edges with a live M/W pipe -> all outputs 0 immediately. BranchE=1, CondExE=1, ValidE=1 -> BranchTakenE=1 in the same cycle.

Source files
------------

// File: rtl/cond_pipe.sv
// rtl/cond_pipe.sv - NZCV flags register and condition-gated E->M->W control pipeline
// Optional squash counter built only when COND_PIPE_PERF_EN is defined.
module cond_pipe #(
    parameter int RA_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall,
    input  logic            FlushE,
    input  logic            ValidE,
    input  logic            CondExE,
    input  logic [3:0]      ALUFlagsE,
    input  logic [1:0]      FlagWriteE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            MemtoRegE,
    input  logic            PCSrcE,
    input  logic            BranchE,
    input  logic [RA_W-1:0] WA3E,
    output logic [3:0]      Flags,
    output logic            BranchTakenE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            MemtoRegM,
    output logic            PCSrcM,
    output logic [RA_W-1:0] WA3M,
    output logic            RegWriteW,
    output logic            MemtoRegW,
    output logic            PCSrcW,
    output logic [RA_W-1:0] WA3W,
    output logic [15:0]     SquashCount
);

    logic            go;
    logic            live;
    logic [3:0]      flags_q, flags_d;
    logic            reg_write_m_q, reg_write_m_d;
    logic            mem_write_m_q, mem_write_m_d;
    logic            mem_to_reg_m_q, mem_to_reg_m_d;
    logic            pc_src_m_q, pc_src_m_d;
    logic [RA_W-1:0] wa3_m_q, wa3_m_d;
    logic            reg_write_w_q, reg_write_w_d;
    logic            mem_to_reg_w_q, mem_to_reg_w_d;
    logic            pc_src_w_q, pc_src_w_d;
    logic [RA_W-1:0] wa3_w_q, wa3_w_d;

    assign live         = ValidE & ~FlushE;
    assign go           = live & CondExE;
    assign BranchTakenE = BranchE & go;

    always_comb begin
        flags_d        = flags_q;
        reg_write_m_d  = reg_write_m_q;
        mem_write_m_d  = mem_write_m_q;
        mem_to_reg_m_d = mem_to_reg_m_q;
        pc_src_m_d     = pc_src_m_q;
        wa3_m_d        = wa3_m_q;
        reg_write_w_d  = reg_write_w_q;
        mem_to_reg_w_d = mem_to_reg_w_q;
        pc_src_w_d     = pc_src_w_q;
        wa3_w_d        = wa3_w_q;
        // A stalled E instruction is re-presented upstream, so FlushE is moot while Stall is high.
        if (!Stall) begin
            if (go && FlagWriteE[1]) flags_d[3:2] = ALUFlagsE[3:2];
            if (go && FlagWriteE[0]) flags_d[1:0] = ALUFlagsE[1:0];
            reg_write_m_d  = RegWriteE & go;
            mem_write_m_d  = MemWriteE & go;
            pc_src_m_d     = PCSrcE & go;
            mem_to_reg_m_d = MemtoRegE & live;
            wa3_m_d        = live ? WA3E : '0;
            reg_write_w_d  = reg_write_m_q;
            mem_to_reg_w_d = mem_to_reg_m_q;
            pc_src_w_d     = pc_src_m_q;
            wa3_w_d        = wa3_m_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q        <= '0;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            pc_src_m_q     <= 1'b0;
            wa3_m_q        <= '0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            pc_src_w_q     <= 1'b0;
            wa3_w_q        <= '0;
        end else begin
            flags_q        <= flags_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            mem_to_reg_m_q <= mem_to_reg_m_d;
            pc_src_m_q     <= pc_src_m_d;
            wa3_m_q        <= wa3_m_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            pc_src_w_q     <= pc_src_w_d;
            wa3_w_q        <= wa3_w_d;
        end
    end

    assign Flags     = flags_q;
    assign RegWriteM = reg_write_m_q;
    assign MemWriteM = mem_write_m_q;
    assign MemtoRegM = mem_to_reg_m_q;
    assign PCSrcM    = pc_src_m_q;
    assign WA3M      = wa3_m_q;
    assign RegWriteW = reg_write_w_q;
    assign MemtoRegW = mem_to_reg_w_q;
    assign PCSrcW    = pc_src_w_q;
    assign WA3W      = wa3_w_q;

`ifdef COND_PIPE_PERF_EN
    logic [15:0] squash_q, squash_d;

    always_comb begin
        squash_d = squash_q;
        if (!Stall && live && !CondExE && squash_q != 16'hFFFF) squash_d = squash_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) squash_q <= '0;
        else        squash_q <= squash_d;
    end

    assign SquashCount = squash_q;
`else
    assign SquashCount = 16'h0000;
`endif

endmodule

// File: tb/tb_cond_pipe.sv
// tb/tb_cond_pipe.sv - table-driven self-checking bench for cond_pipe
module tb_cond_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, FlushE, ValidE, CondExE;
    logic [3:0]  ALUFlagsE;
    logic [1:0]  FlagWriteE;
    logic        RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE;
    logic [3:0]  WA3E;
    logic [3:0]  Flags;
    logic        BranchTakenE;
    logic        RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
    logic [3:0]  WA3M;
    logic        RegWriteW, MemtoRegW, PCSrcW;
    logic [3:0]  WA3W;
    logic [15:0] SquashCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cond_pipe #(.RA_W(4)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .FlushE(FlushE), .ValidE(ValidE),
        .CondExE(CondExE), .ALUFlagsE(ALUFlagsE), .FlagWriteE(FlagWriteE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .PCSrcE(PCSrcE), .BranchE(BranchE), .WA3E(WA3E),
        .Flags(Flags), .BranchTakenE(BranchTakenE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .PCSrcM(PCSrcM), .WA3M(WA3M),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .WA3W(WA3W),
        .SquashCount(SquashCount)
    );

    // ctl_in = {RegWrite, MemWrite, MemtoReg, PCSrc, Branch}
    // exp_m  = {RegWriteM, MemWriteM, MemtoRegM, PCSrcM}; exp_w = {RegWriteW, MemtoRegW, PCSrcW}
    typedef struct {
        logic        stall, flush, valid, cond;
        logic [3:0]  alu;
        logic [1:0]  fw;
        logic [4:0]  ctl_in;
        logic [3:0]  wa3;
        logic        exp_bt;
        logic [3:0]  exp_flags;
        logic [3:0]  exp_m;
        logic [3:0]  exp_wa3m;
        logic [2:0]  exp_w;
        logic [3:0]  exp_wa3w;
        logic [15:0] exp_sq;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sq_exp(input logic [15:0] v);
`ifdef COND_PIPE_PERF_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    task automatic drive_idle();
        Stall = 0; FlushE = 0; ValidE = 0; CondExE = 0; ALUFlagsE = 0; FlagWriteE = 0;
        RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; PCSrcE = 0; BranchE = 0; WA3E = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " Flags"}, {12'h0, Flags}, 16'h0);
        check({tag, " Mctl"}, {12'h0, RegWriteM, MemWriteM, MemtoRegM, PCSrcM}, 16'h0);
        check({tag, " WA3M"}, {12'h0, WA3M}, 16'h0);
        check({tag, " Wctl"}, {13'h0, RegWriteW, MemtoRegW, PCSrcW}, 16'h0);
        check({tag, " WA3W"}, {12'h0, WA3W}, 16'h0);
        check({tag, " SquashCount"}, SquashCount, 16'h0);
    endtask

    initial begin
        //          stall flush valid cond alu      fw     ctl_in    wa3  bt   flags    m        wa3m  w       wa3w  sq
        vecs[0]  = '{0, 0, 1, 1, 4'b0110, 2'b11, 5'b10000, 4'd1,  0, 4'b0110, 4'b1000, 4'd1,  3'b000, 4'd0,  16'd0};
        vecs[1]  = '{0, 0, 1, 1, 4'b1001, 2'b01, 5'b00100, 4'd2,  0, 4'b0101, 4'b0010, 4'd2,  3'b100, 4'd1,  16'd0};
        vecs[2]  = '{0, 0, 1, 0, 4'b1111, 2'b11, 5'b11000, 4'd3,  0, 4'b0101, 4'b0000, 4'd3,  3'b010, 4'd2,  16'd1};
        vecs[3]  = '{0, 0, 1, 1, 4'b0000, 2'b00, 5'b10000, 4'd5,  0, 4'b0101, 4'b1000, 4'd5,  3'b000, 4'd3,  16'd1};
        vecs[4]  = '{0, 0, 1, 1, 4'b0000, 2'b00, 5'b00011, 4'd7,  1, 4'b0101, 4'b0001, 4'd7,  3'b100, 4'd5,  16'd1};
        vecs[5]  = '{0, 1, 1, 1, 4'b0000, 2'b00, 5'b10001, 4'd6,  0, 4'b0101, 4'b0000, 4'd0,  3'b001, 4'd7,  16'd1};
        vecs[6]  = '{0, 0, 0, 0, 4'b0000, 2'b00, 5'b10000, 4'd4,  0, 4'b0101, 4'b0000, 4'd0,  3'b000, 4'd0,  16'd1};
        vecs[7]  = '{0, 0, 1, 1, 4'b1010, 2'b10, 5'b11000, 4'd9,  0, 4'b1001, 4'b1100, 4'd9,  3'b000, 4'd0,  16'd1};
        vecs[8]  = '{1, 1, 1, 1, 4'b0000, 2'b11, 5'b10001, 4'd10, 0, 4'b1001, 4'b1100, 4'd9,  3'b000, 4'd0,  16'd1};
        vecs[9]  = '{1, 1, 1, 0, 4'b0000, 2'b11, 5'b10000, 4'd10, 0, 4'b1001, 4'b1100, 4'd9,  3'b000, 4'd0,  16'd1};
        vecs[10] = '{1, 1, 1, 1, 4'b0110, 2'b11, 5'b11110, 4'd10, 0, 4'b1001, 4'b1100, 4'd9,  3'b000, 4'd0,  16'd1};
        vecs[11] = '{0, 0, 1, 1, 4'b0000, 2'b00, 5'b00100, 4'd11, 0, 4'b1001, 4'b0010, 4'd11, 3'b100, 4'd9,  16'd1};
        vecs[12] = '{0, 0, 1, 0, 4'b0110, 2'b11, 5'b10000, 4'd12, 0, 4'b1001, 4'b0000, 4'd12, 3'b010, 4'd11, 16'd2};
        vecs[13] = '{1, 0, 1, 1, 4'b0000, 2'b00, 5'b00001, 4'd13, 1, 4'b1001, 4'b0000, 4'd12, 3'b010, 4'd11, 16'd2};

        drive_idle();
        reset = 0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) reset = 1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            Stall = vecs[i].stall; FlushE = vecs[i].flush; ValidE = vecs[i].valid;
            CondExE = vecs[i].cond; ALUFlagsE = vecs[i].alu; FlagWriteE = vecs[i].fw;
            {RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE} = vecs[i].ctl_in;
            WA3E = vecs[i].wa3;
            #1 check($sformatf("v%0d BranchTakenE", i), {15'h0, BranchTakenE}, {15'h0, vecs[i].exp_bt});
            @(posedge clk);
            #1;
            check($sformatf("v%0d Flags", i), {12'h0, Flags}, {12'h0, vecs[i].exp_flags});
            check($sformatf("v%0d Mctl", i), {12'h0, RegWriteM, MemWriteM, MemtoRegM, PCSrcM}, {12'h0, vecs[i].exp_m});
            check($sformatf("v%0d WA3M", i), {12'h0, WA3M}, {12'h0, vecs[i].exp_wa3m});
            check($sformatf("v%0d Wctl", i), {13'h0, RegWriteW, MemtoRegW, PCSrcW}, {13'h0, vecs[i].exp_w});
            check($sformatf("v%0d WA3W", i), {12'h0, WA3W}, {12'h0, vecs[i].exp_wa3w});
            check($sformatf("v%0d SquashCount", i), SquashCount, sq_exp(vecs[i].exp_sq));
        end

        // Live pipe, then asynchronous reset between edges.
        @(negedge clk);
        drive_idle();
        ValidE = 1; CondExE = 1; RegWriteE = 1; FlagWriteE = 2'b11; ALUFlagsE = 4'b1111; WA3E = 4'd14;
        @(posedge clk);
        @(negedge clk);
        WA3E = 4'd15;
        @(posedge clk);
        #1;
        check("prereset WA3W", {12'h0, WA3W}, 16'd14);
        check("prereset Flags", {12'h0, Flags}, 16'h000F);
        #2 reset = 0;
        #1 check_all_zero("async reset");
        check("reset RegWriteE WA3 still live bt", {15'h0, BranchTakenE}, 16'h0);
        BranchE = 1;
        #1 check("bt same cycle", {15'h0, BranchTakenE}, 16'h1);
        @(negedge clk) reset = 1;
        drive_idle();
        @(posedge clk);
        #1 check_all_zero("post reset idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
